// File: rtl/scaler_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scaler_arb_pkg
// Brief    : Shared types and constants for the scaler channel-read arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package scaler_arb_pkg;

  localparam int HALF_W = 14;
  localparam int FULL_W = 2 * HALF_W;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DNL = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    HI1  = 3'd2,
    LO1  = 3'd3,
    HI2  = 3'd4,
    LO2  = 3'd5,
    DONE = 3'd6
  } state_t;

  typedef enum logic {
    HALF_HI = 1'b0,
    HALF_LO = 1'b1
  } half_t;

endpackage
`default_nettype wire

// File: rtl/scaler_read_port.sv
`default_nettype none
// ============================================================================
// Module   : scaler_read_port
// Brief    : Drives one active-low half-read strobe for STROBE_CYCLES cycles
//            and flags the last strobe cycle, when the bus is sampled.
// Revision : 1.0 - initial release
// ============================================================================
module scaler_read_port #(
  parameter int STROBE_CYCLES = 2,
  parameter int HALF_W        = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  scaler_arb_pkg::half_t i_sel,
  input  logic [HALF_W-1:0]     i_chat,
  input  logic [HALF_W-1:0]     i_chbt,
  output logic                  o_rchat_n,
  output logic                  o_rchbt_n,
  output logic [HALF_W-1:0]     o_data,
  output logic                  o_done
);
  import scaler_arb_pkg::*;

  localparam logic [3:0] c_last_cnt = 4'(STROBE_CYCLES - 1);

  logic       r_active;
  logic [3:0] r_cnt;
  half_t      r_sel;
  logic       r_strb_hi_n;
  logic       r_strb_lo_n;

  // The caller never restarts before one idle cycle has passed, which gives the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active    <= 1'b0;
      r_cnt       <= 4'd0;
      r_sel       <= HALF_HI;
      r_strb_hi_n <= 1'b1;
      r_strb_lo_n <= 1'b1;
    end else if (i_start) begin
      r_active    <= 1'b1;
      r_cnt       <= 4'd0;
      r_sel       <= i_sel;
      r_strb_hi_n <= (i_sel != HALF_HI);
      r_strb_lo_n <= (i_sel != HALF_LO);
    end else if (r_active) begin
      if (r_cnt == c_last_cnt) begin
        r_active    <= 1'b0;
        r_strb_hi_n <= 1'b1;
        r_strb_lo_n <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign o_done    = r_active && (r_cnt == c_last_cnt);
  assign o_data    = (r_sel == HALF_LO) ? i_chbt : i_chat;
  assign o_rchat_n = r_strb_hi_n;
  assign o_rchbt_n = r_strb_lo_n;

endmodule
`default_nettype wire

// File: rtl/scaler_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : scaler_read_arbiter
// Brief    : Shares the scaler channel-read port between CPU and downlink and
//            returns a carry-coherent 28-bit snapshot.
//            SCALER_ARB_RR_EN selects round-robin instead of fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module scaler_read_arbiter #(
  parameter int STROBE_CYCLES = 2,
  parameter int HALF_W        = 14
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic [1:0]            REQ,
  output logic [1:0]            GNT,
  output logic [1:0]            ACK,
  output logic [2*HALF_W-1:0]   DATA,
  output logic                  RCHAT_,
  output logic                  RCHBT_,
  input  logic [HALF_W-1:0]     CHAT,
  input  logic [HALF_W-1:0]     CHBT,
  output logic [7:0]            RETRIES
);
  import scaler_arb_pkg::*;

  state_t                r_state;
  logic [1:0]            r_req_q;
  logic [1:0]            r_gnt;
  logic [1:0]            r_ack;
  logic [2*HALF_W-1:0]   r_data;
  logic [7:0]            r_retries;
  logic [HALF_W-1:0]     r_h1;
  logic [HALF_W-1:0]     r_l1;
  logic [HALF_W-1:0]     r_h2;
  logic                  r_start;
`ifdef SCALER_ARB_RR_EN
  logic                  r_last;
`endif

  logic                  w_winner;
  logic [1:0]            w_gnt_oh;
  half_t                 w_start_sel;
  logic [HALF_W-1:0]     w_rd_data;
  logic                  w_rd_done;

  always_comb begin
    w_winner = REQ_CPU;
    if (r_req_q[REQ_DNL] && !r_req_q[REQ_CPU]) begin
      w_winner = REQ_DNL;
    end
`ifdef SCALER_ARB_RR_EN
    if (r_req_q[REQ_DNL] && r_req_q[REQ_CPU] && (r_last == REQ_CPU)) begin
      w_winner = REQ_DNL;
    end
`endif
  end

  assign w_gnt_oh = (w_winner == REQ_DNL) ? 2'b10 : 2'b01;

  // Start is issued one cycle ahead of the strobe, so the select follows the upcoming read.
  assign w_start_sel = ((r_state == LO1) || (r_state == LO2)) ? HALF_LO : HALF_HI;

  scaler_read_port #(
    .STROBE_CYCLES (STROBE_CYCLES),
    .HALF_W        (HALF_W)
  ) u_read_port (
    .clk       (clk),
    .rst_n     (rst_),
    .i_start   (r_start),
    .i_sel     (w_start_sel),
    .i_chat    (CHAT),
    .i_chbt    (CHBT),
    .o_rchat_n (RCHAT_),
    .o_rchbt_n (RCHBT_),
    .o_data    (w_rd_data),
    .o_done    (w_rd_done)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state   <= IDLE;
      r_req_q   <= 2'b00;
      r_gnt     <= 2'b00;
      r_ack     <= 2'b00;
      r_data    <= '0;
      r_retries <= 8'd0;
      r_h1      <= '0;
      r_l1      <= '0;
      r_h2      <= '0;
      r_start   <= 1'b0;
`ifdef SCALER_ARB_RR_EN
      r_last    <= REQ_DNL;
`endif
    end else begin
      r_ack   <= 2'b00;
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|REQ) begin
            r_req_q <= REQ;
            r_start <= 1'b1;
            r_state <= ARB;
          end
        end
        ARB: begin
          r_gnt   <= w_gnt_oh;
`ifdef SCALER_ARB_RR_EN
          r_last  <= w_winner;
`endif
          r_state <= HI1;
        end
        HI1: begin
          if (w_rd_done) begin
            r_h1    <= w_rd_data;
            r_start <= 1'b1;
            r_state <= LO1;
          end
        end
        LO1: begin
          if (w_rd_done) begin
            r_l1    <= w_rd_data;
            r_start <= 1'b1;
            r_state <= HI2;
          end
        end
        HI2: begin
          if (w_rd_done) begin
            if (w_rd_data == r_h1) begin
              r_data  <= {r_h1, r_l1};
              r_ack   <= r_gnt;
              r_state <= DONE;
            end else begin
              // The low half carried into the high half between reads; re-read low.
              r_h2    <= w_rd_data;
              r_start <= 1'b1;
              if (r_retries != 8'hFF) begin
                r_retries <= r_retries + 8'd1;
              end
              r_state <= LO2;
            end
          end
        end
        LO2: begin
          if (w_rd_done) begin
            r_data  <= {r_h2, w_rd_data};
            r_ack   <= r_gnt;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_gnt   <= 2'b00;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign GNT     = r_gnt;
  assign ACK     = r_ack;
  assign DATA    = r_data;
  assign RETRIES = r_retries;

endmodule
`default_nettype wire

// File: tb/tb_scaler_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_scaler_read_arbiter
// Brief    : Randomized self-checking bench for scaler_read_arbiter against a
//            timeline-based snapshot model of the scaler bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scaler_read_arbiter;

  localparam int S  = 2;
  localparam int HW = 14;

  logic          clk = 1'b0;
  logic          rst_;
  logic [1:0]    REQ;
  logic [1:0]    GNT;
  logic [1:0]    ACK;
  logic [2*HW-1:0] DATA;
  logic          RCHAT_;
  logic          RCHBT_;
  logic [HW-1:0] CHAT;
  logic [HW-1:0] CHBT;
  logic [7:0]    RETRIES;

  logic [2*HW-1:0] scal;
  assign CHAT = scal[2*HW-1:HW];
  assign CHBT = scal[HW-1:0];

  int checks = 0;
  int errors = 0;

  // Reference state: last winner, retry count, last returned snapshot.
  logic        m_last;
  int          m_retries;
  logic [27:0] m_data;

  always #5 clk = ~clk;

  scaler_read_arbiter #(
    .STROBE_CYCLES (S),
    .HALF_W        (HW)
  ) dut (
    .clk     (clk),
    .rst_    (rst_),
    .REQ     (REQ),
    .GNT     (GNT),
    .ACK     (ACK),
    .DATA    (DATA),
    .RCHAT_  (RCHAT_),
    .RCHBT_  (RCHBT_),
    .CHAT    (CHAT),
    .CHBT    (CHBT),
    .RETRIES (RETRIES)
  );

  // Strobe protocol: never both low, each low run lasts S cycles, an idle cycle precedes every run.
  int   mon_a = 0;
  int   mon_b = 0;
  logic mon_prev_idle = 1'b1;
  always @(negedge clk) begin
    if (rst_ !== 1'b1) begin
      mon_a = 0;
      mon_b = 0;
      mon_prev_idle = 1'b1;
    end else begin
      if (!RCHAT_ && !RCHBT_) begin
        checks++; errors++;
        $display("FAIL strobe_overlap RCHAT_=%b RCHBT_=%b required not both 0", RCHAT_, RCHBT_);
      end
      if (!RCHAT_) begin
        if (mon_a == 0) begin
          checks++;
          if (!mon_prev_idle) begin
            errors++; $display("FAIL strobe_gap_hi no idle cycle before high-half read");
          end
        end
        mon_a++;
      end else if (mon_a != 0) begin
        checks++;
        if (mon_a != S) begin
          errors++; $display("FAIL strobe_len_hi got %0d required %0d", mon_a, S);
        end
        mon_a = 0;
      end
      if (!RCHBT_) begin
        if (mon_b == 0) begin
          checks++;
          if (!mon_prev_idle) begin
            errors++; $display("FAIL strobe_gap_lo no idle cycle before low-half read");
          end
        end
        mon_b++;
      end else if (mon_b != 0) begin
        checks++;
        if (mon_b != S) begin
          errors++; $display("FAIL strobe_len_lo got %0d required %0d", mon_b, S);
        end
        mon_b = 0;
      end
      mon_prev_idle = RCHAT_ && RCHBT_;
    end
  end

  function automatic logic [27:0] val_at(input int c, input int carry_at,
                                         input logic [27:0] v0, input logic [27:0] v1);
    return (c >= carry_at) ? v1 : v0;
  endfunction

  function automatic logic [1:0] pick(input logic [1:0] req);
    if (req == 2'b01) return 2'b01;
    if (req == 2'b10) return 2'b10;
`ifdef SCALER_ARB_RR_EN
    return m_last ? 2'b01 : 2'b10;
`else
    return 2'b01;
`endif
  endfunction

  // Entered in the cycle where REQ is sampled (cycle 0); returns in the ACK cycle.
  // Bus values are sampled at the end of cycles S+1, 2S+2, 3S+3 and (on retry) 4S+4.
  task automatic run_txn(input logic [1:0] req, input logic [27:0] v0, input logic [27:0] v1,
                         input int carry_at, input bit keep, input bit drop_mid, input string name);
    logic [1:0]  exp_g;
    logic [27:0] tmp;
    logic [13:0] h1, l1, h2, l2;
    logic [27:0] exp_d;
    int          exp_cyc;
    bit          got;
    exp_g  = pick(req);
    m_last = exp_g[1];
    tmp = val_at(S + 1, carry_at, v0, v1);     h1 = tmp[27:14];
    tmp = val_at(2 * S + 2, carry_at, v0, v1); l1 = tmp[13:0];
    tmp = val_at(3 * S + 3, carry_at, v0, v1); h2 = tmp[27:14];
    tmp = val_at(4 * S + 4, carry_at, v0, v1); l2 = tmp[13:0];
    if (h1 == h2) begin
      exp_d = {h1, l1}; exp_cyc = 3 * S + 4;
    end else begin
      exp_d = {h2, l2}; exp_cyc = 4 * S + 5;
      if (m_retries < 255) m_retries++;
    end
    REQ  = req;
    scal = val_at(0, carry_at, v0, v1);
    got  = 1'b0;
    for (int k = 1; k <= 4 * S + 12 && !got; k++) begin
      @(posedge clk); #1;
      scal = val_at(k, carry_at, v0, v1);
      if (drop_mid && k == 3) REQ = 2'b00;
      if (k == 2) begin
        checks++;
        if (GNT !== exp_g) begin
          errors++; $display("FAIL %s gnt got %b required %b", name, GNT, exp_g);
        end
      end
      if (ACK !== 2'b00) begin
        got = 1'b1;
        checks++;
        if (k != exp_cyc || ACK !== exp_g) begin
          errors++;
          $display("FAIL %s ack got %b at cycle %0d required %b at cycle %0d", name, ACK, k, exp_g, exp_cyc);
        end
        checks++;
        if (DATA !== exp_d) begin
          errors++; $display("FAIL %s data got %h required %h", name, DATA, exp_d);
        end
        checks++;
        if (RETRIES !== 8'(m_retries)) begin
          errors++; $display("FAIL %s retries got %0d required %0d", name, RETRIES, m_retries);
        end
        m_data = exp_d;
        if (!keep) REQ = REQ & ~exp_g;
      end else begin
        checks++;
        if (DATA !== m_data) begin
          errors++; $display("FAIL %s data_hold got %h required %h", name, DATA, m_data);
        end
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s ack_timeout got none required at cycle %0d", name, exp_cyc);
    end
  endtask

  task automatic apply_reset_model();
    m_last = 1'b1; m_retries = 0; m_data = '0;
  endtask

  task automatic test_reset();
    rst_ = 1'b0; REQ = 2'b00; scal = '0;
    apply_reset_model();
    repeat (3) @(posedge clk);
    #1 rst_ = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({RCHAT_, RCHBT_, ACK, GNT, DATA, RETRIES} !== {2'b11, 2'b00, 2'b00, 28'h0, 8'h0}) begin
        errors++;
        $display("FAIL reset_idle got strb=%b%b ack=%b gnt=%b data=%h ret=%0d required 11/00/00/0/0",
                 RCHAT_, RCHBT_, ACK, GNT, DATA, RETRIES);
      end
    end
  endtask

  task automatic test_single_cpu();
    @(posedge clk); #1;
    run_txn(2'b01, {14'h0012, 14'h3ABC}, {14'h0012, 14'h3ABC}, 1000, 1'b0, 1'b0, "single_cpu");
    checks++;
    if (DATA !== 28'h0004BABC || RETRIES !== 8'd0) begin
      errors++; $display("FAIL single_cpu_const got %h/%0d required 0004babc/0", DATA, RETRIES);
    end
    @(posedge clk); #1;
    checks++;
    if (ACK !== 2'b00 || GNT !== 2'b00) begin
      errors++; $display("FAIL single_cpu_release got ack=%b gnt=%b required 00/00", ACK, GNT);
    end
  endtask

  task automatic test_carry();
    @(posedge clk); #1;
    run_txn(2'b01, {14'h0012, 14'h3FFF}, {14'h0013, 14'h0000}, 2 * S + 3, 1'b0, 1'b0, "carry");
    checks++;
    if (DATA !== 28'h0004C000 || RETRIES !== 8'd1) begin
      errors++; $display("FAIL carry_const got %h/%0d required 0004c000/1", DATA, RETRIES);
    end
  endtask

  task automatic test_random();
    logic [27:0] v0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      v0 = 28'($urandom);
      run_txn(2'($urandom_range(1, 2)), v0, v0 + 28'($urandom_range(0, 300)),
              int'($urandom_range(0, 4 * S + 6)), 1'b0, bit'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      run_txn(2'b11, 28'h0123456, 28'h0123456, 1000, 1'b1, 1'b0, "simultaneous");
    end
    REQ = 2'b00;
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    REQ = 2'b01; scal = 28'h0ABCDEF;
    repeat (S + 3) @(posedge clk);
    #1;
    checks++;
    if (RCHBT_ !== 1'b0) begin
      errors++; $display("FAIL midreset_in_lo1 got RCHBT_=%b required 0", RCHBT_);
    end
    #2 rst_ = 1'b0; REQ = 2'b00;
    #1;
    checks++;
    if ({RCHAT_, RCHBT_, ACK, GNT, DATA, RETRIES} !== {2'b11, 2'b00, 2'b00, 28'h0, 8'h0}) begin
      errors++;
      $display("FAIL midreset_async got strb=%b%b ack=%b gnt=%b data=%h ret=%0d required 11/00/00/0/0",
               RCHAT_, RCHBT_, ACK, GNT, DATA, RETRIES);
    end
    apply_reset_model();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ACK !== 2'b00) begin
        errors++; $display("FAIL midreset_no_ack got %b required 00", ACK);
      end
    end
    rst_ = 1'b1;
    @(posedge clk); #1;
    run_txn(2'b10, 28'h1234567, 28'h1234567, 1000, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      run_txn(2'b01, {14'h0012, 14'h3FFF}, {14'h0013, 14'h0000}, 2 * S + 3, 1'b0, 1'b0, "saturate");
    end
    checks++;
    if (RETRIES !== 8'd255) begin
      errors++; $display("FAIL saturate_final got %0d required 255", RETRIES);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_cpu();
    test_carry();
    test_random();
    test_simultaneous();
    test_reset_mid_read();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
